// File: rtl/motor_pkg.sv
// motor_pkg: mode codes, direction/state types and bridge pin encodings for motor_ctrl
package motor_pkg;
  localparam logic [4:0] MODE_IDLE     = 5'd0;
  localparam logic [4:0] MODE_START    = 5'd1;
  localparam logic [4:0] MODE_COUNT    = 5'd2;
  localparam logic [4:0] MODE_STRAIGHT = 5'd3;
  localparam logic [4:0] MODE_CHOOSE   = 5'd4;
  localparam logic [4:0] MODE_LEFT     = 5'd5;
  localparam logic [4:0] MODE_RIGHT    = 5'd6;
  localparam logic [4:0] MODE_BACK     = 5'd7;
  localparam logic [4:0] MODE_STOP     = 5'd30;
  localparam logic [4:0] MODE_ERROR    = 5'd31;
  typedef enum logic [1:0] {DIR_OFF, DIR_FWD, DIR_REV} dir_t;
  typedef enum logic [1:0] {W_RUN, W_RAMPDN, W_DEAD} wstate_t;
  localparam logic [1:0] IN_COAST = 2'b00;
  localparam logic [1:0] IN_FWD   = 2'b10;
  localparam logic [1:0] IN_REV   = 2'b01;
  localparam logic [1:0] IN_BRAKE = 2'b11;
  function automatic logic [1:0] dir_in(dir_t d);
    return d == DIR_FWD ? IN_FWD : d == DIR_REV ? IN_REV : IN_COAST;
  endfunction
endpackage

// File: rtl/motor_ctrl_wheel.sv
// wheel_drive: one wheel's ramp/dead-time FSM; MOTOR_BRAKE_EN makes OFF targets brake instantly
module wheel_drive
  import motor_pkg::*;
#(
  parameter int DW          = 10,
  parameter int RAMP_STEP   = 64,
  parameter int DEAD_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  dir_t          i_tgt_dir,
  input  logic [DW-1:0] i_tgt_duty,
  input  logic          i_tick,
  output logic [DW-1:0] o_duty,
  output logic [1:0]    o_in,
  output logic          o_ok
);
  localparam int CW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
`ifdef MOTOR_BRAKE_EN
  localparam bit BRAKE = 1'b1;
  localparam logic [1:0] IN_STOP = IN_BRAKE;
`else
  localparam bit BRAKE = 1'b0;
  localparam logic [1:0] IN_STOP = IN_COAST;
`endif
  wstate_t       r_state;
  dir_t          r_dir;
  logic [DW-1:0] r_duty;
  logic [CW-1:0] r_dead;
  logic [1:0]    r_in;
  logic [DW-1:0] w_diff, w_toward, w_down;
  // next duty one ramp step toward the target, and one step toward zero, both clamped
  always_comb begin
    w_diff   = i_tgt_duty > r_duty ? i_tgt_duty - r_duty : r_duty - i_tgt_duty;
    w_toward = i_tgt_duty > r_duty ? r_duty + (w_diff > STEP ? STEP : w_diff)
                                   : r_duty - (w_diff > STEP ? STEP : w_diff);
    w_down   = r_duty - (r_duty > STEP ? STEP : r_duty);
  end
  // wheel FSM: reversals ramp to zero then coast before the new direction is applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= W_RUN;
      r_dir   <= DIR_OFF;
      r_duty  <= '0;
      r_dead  <= '0;
      r_in    <= IN_COAST;
    end else begin
      case (r_state)
        W_RUN:
          if (BRAKE && i_tgt_dir == DIR_OFF) begin
            r_duty <= '0;
            r_dir  <= DIR_OFF;
            r_in   <= IN_STOP;
          end else if (r_dir != DIR_OFF && i_tgt_dir != r_dir) begin
            r_state <= W_RAMPDN;
          end else if (r_dir == DIR_OFF && i_tgt_dir != DIR_OFF) begin
            r_state <= W_DEAD;
            r_dead  <= '0;
            r_duty  <= '0;
            r_in    <= IN_COAST;
          end else if (i_tick) begin
            r_duty <= w_toward;
          end
        W_RAMPDN:
          if (BRAKE && i_tgt_dir == DIR_OFF) begin
            r_state <= W_RUN;
            r_duty  <= '0;
            r_dir   <= DIR_OFF;
            r_in    <= IN_STOP;
          end else if (r_duty == '0) begin
            r_dir   <= DIR_OFF;
            r_dead  <= '0;
            r_state <= i_tgt_dir != DIR_OFF ? W_DEAD : W_RUN;
            r_in    <= i_tgt_dir != DIR_OFF ? IN_COAST : IN_STOP;
          end else if (i_tick) begin
            r_duty <= w_down;
          end
        W_DEAD:
          if (i_tgt_dir == DIR_OFF) begin
            r_state <= W_RUN;
            r_dead  <= '0;
            r_in    <= IN_STOP;
          end else if (r_dead == DEAD_LAST) begin
            r_state <= W_RUN;
            r_dead  <= '0;
            r_dir   <= i_tgt_dir;
            r_in    <= dir_in(i_tgt_dir);
          end else begin
            r_dead <= r_dead + 1'b1;
          end
        default: r_state <= W_RUN;
      endcase
    end
  end
  assign o_duty = r_duty;
  assign o_in   = r_in;
  assign o_ok   = r_state == W_RUN && r_dir == i_tgt_dir && r_duty == i_tgt_duty;
endmodule

// File: rtl/motor_ctrl.sv
// motor_ctrl: mode-driven dual H-bridge PWM driver with ramp and dead-time; MOTOR_BRAKE_EN enables braking
module motor_ctrl
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD    = 1024,
  parameter int DUTY_FWD      = 768,
  parameter int DUTY_TURN_OUT = 768,
  parameter int DUTY_TURN_IN  = 256,
  parameter int DUTY_BACK     = 512,
  parameter int RAMP_DIV      = 100000,
  parameter int RAMP_STEP     = 64,
  parameter int DEAD_CYCLES   = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] mode,
  output logic [1:0] pwm,
  output logic [1:0] l_IN,
  output logic [1:0] r_IN,
  output logic       settled
);
  localparam int DW = $clog2(PWM_PERIOD);
  localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] PWM_LAST = DW'(PWM_PERIOD - 1);
  logic [4:0]    r_mode;
  logic [PW-1:0] r_pre;
  logic [DW-1:0] r_pcnt, r_l_app, r_r_app;
  logic [1:0]    r_pwm;
  logic          r_settled;
  dir_t          w_l_dir, w_r_dir;
  logic [DW-1:0] w_l_duty, w_r_duty, w_l_ramp, w_r_ramp;
  logic          w_tick, w_l_ok, w_r_ok;
  // register the navigation state once; targets derive from the registered copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= '0;
    else r_mode <= mode;
  end
  // per-wheel target direction and duty; unknown codes stop both wheels
  always_comb begin
    w_l_dir  = DIR_OFF;
    w_r_dir  = DIR_OFF;
    w_l_duty = '0;
    w_r_duty = '0;
    case (r_mode)
      MODE_STRAIGHT, MODE_CHOOSE: begin
        w_l_dir = DIR_FWD; w_r_dir = DIR_FWD; w_l_duty = DW'(DUTY_FWD); w_r_duty = DW'(DUTY_FWD);
      end
      MODE_LEFT: begin
        w_l_dir = DIR_REV; w_r_dir = DIR_FWD; w_l_duty = DW'(DUTY_TURN_IN); w_r_duty = DW'(DUTY_TURN_OUT);
      end
      MODE_RIGHT: begin
        w_l_dir = DIR_FWD; w_r_dir = DIR_REV; w_l_duty = DW'(DUTY_TURN_OUT); w_r_duty = DW'(DUTY_TURN_IN);
      end
      MODE_BACK: begin
        w_l_dir = DIR_REV; w_r_dir = DIR_REV; w_l_duty = DW'(DUTY_BACK); w_r_duty = DW'(DUTY_BACK);
      end
      default: ;
    endcase
  end
  // free-running ramp prescaler shared by both wheels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pre <= '0;
    else r_pre <= w_tick ? '0 : r_pre + 1'b1;
  end
  assign w_tick = r_pre == PRE_LAST;
  wheel_drive #(.DW(DW), .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)) u_left (
    .clk(clk), .rst_n(rst_n), .i_tgt_dir(w_l_dir), .i_tgt_duty(w_l_duty), .i_tick(w_tick),
    .o_duty(w_l_ramp), .o_in(l_IN), .o_ok(w_l_ok)
  );
  wheel_drive #(.DW(DW), .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)) u_right (
    .clk(clk), .rst_n(rst_n), .i_tgt_dir(w_r_dir), .i_tgt_duty(w_r_duty), .i_tick(w_tick),
    .o_duty(w_r_ramp), .o_in(r_IN), .o_ok(w_r_ok)
  );
  // PWM counter; duties are latched only at period end so pulses never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt  <= '0;
      r_l_app <= '0;
      r_r_app <= '0;
      r_pwm   <= 2'b00;
    end else begin
      r_pcnt  <= r_pcnt == PWM_LAST ? '0 : r_pcnt + 1'b1;
      r_l_app <= r_pcnt == PWM_LAST ? w_l_ramp : r_l_app;
      r_r_app <= r_pcnt == PWM_LAST ? w_r_ramp : r_r_app;
      r_pwm   <= {r_pcnt < r_l_app, r_pcnt < r_r_app};
    end
  end
  // both wheels running at their commanded direction and duty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_settled <= 1'b0;
    else r_settled <= w_l_ok & w_r_ok;
  end
  assign pwm     = r_pwm;
  assign settled = r_settled;
endmodule

// File: tb/tb_motor_ctrl.sv
// tb_motor_ctrl: table-driven steady-state vectors plus directed reversal, abort and reset sequences
module tb_motor_ctrl;
`ifdef MOTOR_BRAKE_EN
  localparam logic [1:0] IN_OFF = 2'b11;
`else
  localparam logic [1:0] IN_OFF = 2'b00;
`endif
  typedef struct {
    logic [4:0] mode;
    logic [1:0] l_in;
    logic [1:0] r_in;
    logic       set;
    int         lh;
    int         rh;
  } vec_t;
  localparam int NV = 15;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] mode = 5'd0;
  logic [1:0] pwm, l_IN, r_IN;
  logic       settled;
  int total = 0;
  int bad = 0;
  vec_t vecs[NV];
  motor_ctrl #(
    .PWM_PERIOD(16), .DUTY_FWD(12), .DUTY_TURN_OUT(12), .DUTY_TURN_IN(4), .DUTY_BACK(8),
    .RAMP_DIV(4), .RAMP_STEP(4), .DEAD_CYCLES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .pwm(pwm), .l_IN(l_IN), .r_IN(r_IN), .settled(settled)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic measure(output int lh, output int rh);
    lh = 0;
    rh = 0;
    repeat (16) begin
      @(negedge clk);
      lh += int'(pwm[1]);
      rh += int'(pwm[0]);
    end
  endtask
  task automatic wait_lin(input logic [1:0] want, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (l_IN !== want && n < 100);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n, lh, rh, n10, n00, rbad, early, idx;
    vecs[0]  = '{5'd0,  IN_OFF, IN_OFF, 1'b1, 0,  0};
    vecs[1]  = '{5'd3,  2'b10,  2'b10,  1'b1, 12, 12};
    vecs[2]  = '{5'd5,  2'b01,  2'b10,  1'b1, 4,  12};
    vecs[3]  = '{5'd6,  2'b10,  2'b01,  1'b1, 12, 4};
    vecs[4]  = '{5'd7,  2'b01,  2'b01,  1'b1, 8,  8};
    vecs[5]  = '{5'd4,  2'b10,  2'b10,  1'b1, 12, 12};
    vecs[6]  = '{5'd9,  IN_OFF, IN_OFF, 1'b1, 0,  0};
    vecs[7]  = '{5'd1,  IN_OFF, IN_OFF, 1'b1, 0,  0};
    vecs[8]  = '{5'd3,  2'b10,  2'b10,  1'b1, 12, 12};
    vecs[9]  = '{5'd30, IN_OFF, IN_OFF, 1'b1, 0,  0};
    vecs[10] = '{5'd7,  2'b01,  2'b01,  1'b1, 8,  8};
    vecs[11] = '{5'd31, IN_OFF, IN_OFF, 1'b1, 0,  0};
    vecs[12] = '{5'd2,  IN_OFF, IN_OFF, 1'b1, 0,  0};
    vecs[13] = '{5'd5,  2'b01,  2'b10,  1'b1, 4,  12};
    vecs[14] = '{5'd0,  IN_OFF, IN_OFF, 1'b1, 0,  0};
    cyc(2);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_lin", int'(l_IN), 0);
    chk("rst_rin", int'(r_IN), 0);
    chk("rst_settled", int'(settled), 0);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (settled !== 1'b1 && n < 20);
    chk("settled_by_3", int'(n <= 3), 1);
    for (int i = 0; i < NV; i++) begin
      mode = vecs[i].mode;
      cyc(64);
      chk($sformatf("vec%0d_lin", i), int'(l_IN), int'(vecs[i].l_in));
      chk($sformatf("vec%0d_rin", i), int'(r_IN), int'(vecs[i].r_in));
      chk($sformatf("vec%0d_settled", i), int'(settled), int'(vecs[i].set));
      measure(lh, rh);
      chk($sformatf("vec%0d_lhigh", i), lh, vecs[i].lh);
      chk($sformatf("vec%0d_rhigh", i), rh, vecs[i].rh);
    end
    mode = 5'd3;
    wait_lin(2'b10, n);
    chk("start_dead_edges", n, 5);
    chk("start_rin", int'(r_IN), 2);
    measure(lh, rh);
    chk("start_ramping", int'(lh < 12 && rh < 12), 1);
    cyc(64);
    chk("straight_settled", int'(settled), 1);
    mode = 5'd5;
    n10 = 0;
    n00 = 0;
    rbad = 0;
    early = 0;
    idx = 0;
    do begin
      @(negedge clk);
      idx++;
      if (l_IN === 2'b10) n10++;
      if (l_IN === 2'b00) n00++;
      if (r_IN !== 2'b10) rbad++;
      if (idx >= 2 && l_IN !== 2'b01 && settled === 1'b1) early++;
    end while (l_IN !== 2'b01 && idx < 100);
    chk("rev_lin", int'(l_IN), 1);
    chk("rev_settled_at_dir", int'(settled), 0);
    chk("rev_rampdown_len", int'(n10 >= 11 && n10 <= 14), 1);
    chk("rev_coast_cycles", n00, 3);
    chk("rev_right_kept", rbad, 0);
    chk("rev_early_settle", early, 0);
    n = 0;
    while (settled !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rev_settled", int'(settled), 1);
    cyc(20);
    measure(lh, rh);
    chk("rev_lhigh", lh, 4);
    chk("rev_rhigh", rh, 12);
    mode = 5'd0;
    cyc(64);
    mode = 5'd7;
    cyc(2);
    mode = 5'd0;
    rbad = 0;
    repeat (30) begin
      @(negedge clk);
      if (l_IN === 2'b01 || r_IN === 2'b01) rbad++;
    end
    chk("abort_no_rev", rbad, 0);
    chk("abort_lin", int'(l_IN), int'(IN_OFF));
    chk("abort_settled", int'(settled), 1);
    mode = 5'd3;
    wait_lin(2'b10, n);
    chk("pre_rst_dir", n, 5);
    cyc(6);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pwm", int'(pwm), 0);
    chk("midrst_lin", int'(l_IN), 0);
    chk("midrst_rin", int'(r_IN), 0);
    chk("midrst_settled", int'(settled), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_lin(2'b10, n);
    chk("post_rst_dead", n, 5);
    measure(lh, rh);
    chk("post_rst_ramp", int'(lh < 12 && rh < 12), 1);
    cyc(40);
    measure(lh, rh);
    chk("post_rst_lhigh", lh, 12);
    chk("post_rst_rhigh", rh, 12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
